// File: rtl/lpc_frame_ctrl_if.sv
// lpc_frame_ctrl_if
//   Bundles the sample-input handshake, the register-file write/read ports,
//   the frame-hold/readout request and the output stream used by
//   lpc_frame_ctrl.
//   slave  : the frame controller's view (drives in_ready, rf_*, frame_ready,
//            out_*; receives in_valid/in_data, rf_dout, rd_start, out_ready).
//   master : the surrounding system's view (the complementary directions).
interface lpc_frame_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              rf_wen;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_din;
   logic [ADDR_W-1:0] rf_raddr;
   logic [DATA_W-1:0] rf_dout;
   logic              frame_ready;
   logic              rd_start;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, rf_dout, rd_start, out_ready,
      output in_ready, rf_wen, rf_waddr, rf_din, rf_raddr,
             frame_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, rf_dout, rd_start, out_ready,
      input  in_ready, rf_wen, rf_waddr, rf_din, rf_raddr,
             frame_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/lpc_frame_ctrl.sv
// lpc_frame_ctrl
//   Sequencer for the LPC frame register file. Accepts DEPTH samples through
//   in_valid/in_ready and writes them at consecutive addresses, then holds
//   the frame (frame_ready) until rd_start, then streams it out in address
//   order on out_valid/out_ready/out_data/out_last, after which it refills.
//   Ports:
//     clk      - system clock, rising edge
//     reset    - asynchronous, active-high reset
//     frame_cnt- completed-readout counter (only with LPC_FRAME_CNT_EN)
//     bus      - lpc_frame_ctrl_if.slave: sample input, register-file ports,
//                frame hold/request and output stream
//   Optional feature macro: LPC_FRAME_CNT_EN (adds the frame_cnt port).
module lpc_frame_ctrl #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 160,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
`ifdef LPC_FRAME_CNT_EN
   output logic [15:0]       frame_cnt,
`endif
   lpc_frame_ctrl_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, FILL, FULL, PRIME, READ} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] wr_idx_q;
   logic [ADDR_W-1:0] rd_idx_q;
   logic [ADDR_W-1:0] rd_idx_d;
   logic              in_ready_q;
   logic              frame_ready_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              wr_fire;
   logic              rd_fire;
`ifdef LPC_FRAME_CNT_EN
   logic [15:0]       frame_cnt_q;
`endif

   always_comb begin
      wr_fire  = bus.in_valid & in_ready_q;
      rd_fire  = out_valid_q & bus.out_ready;
      rd_idx_d = rd_idx_q + ADDR_W'(1);
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.rf_wen      = wr_fire;
   assign bus.rf_waddr    = wr_idx_q;
   assign bus.rf_din      = in_ready_q ? bus.in_data : '0;
   // Look one address ahead on a handshake so the registered read delivers
   // the next sample on the following clock; otherwise re-read the current
   // one so out_data holds during a stall. rd_idx_q is 0 in PRIME.
   assign bus.rf_raddr    = rd_fire ? rd_idx_d :
                            ((state_q == READ || state_q == PRIME) ? rd_idx_q : '0);
   assign bus.frame_ready = frame_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = bus.rf_dout;
   assign bus.out_last    = out_last_q;
`ifdef LPC_FRAME_CNT_EN
   assign frame_cnt       = frame_cnt_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_idx_q      <= '0;
         rd_idx_q      <= '0;
         in_ready_q    <= 1'b0;
         frame_ready_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
`ifdef LPC_FRAME_CNT_EN
         frame_cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_q    <= FILL;
               wr_idx_q   <= '0;
               in_ready_q <= 1'b1;
            end
            FILL: begin
               if (wr_fire) begin
                  wr_idx_q <= wr_idx_q + ADDR_W'(1);
                  if (wr_idx_q == LAST_IDX) begin
                     state_q       <= FULL;
                     in_ready_q    <= 1'b0;
                     frame_ready_q <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (bus.rd_start) begin
                  state_q       <= PRIME;
                  rd_idx_q      <= '0;
                  frame_ready_q <= 1'b0;
               end
            end
            PRIME: begin
               state_q     <= READ;
               out_valid_q <= 1'b1;
               out_last_q  <= (LAST_IDX == '0);
            end
            READ: begin
               if (rd_fire) begin
                  if (out_last_q) begin
                     state_q     <= FILL;
                     wr_idx_q    <= '0;
                     rd_idx_q    <= '0;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
`ifdef LPC_FRAME_CNT_EN
                     frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                  end else begin
                     rd_idx_q   <= rd_idx_d;
                     out_last_q <= (rd_idx_d == LAST_IDX);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
module tb_lpc_frame_ctrl;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 160;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lpc_frame_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef LPC_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   lpc_frame_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef LPC_FRAME_CNT_EN
      .frame_cnt(frame_cnt),
`endif
      .bus      (bus)
   );

   // Register file: synchronous write, registered read.
   logic [DATA_W-1:0] mem [0:255];
   always @(posedge clk) begin
      if (bus.rf_wen) mem[bus.rf_waddr] <= bus.rf_din;
      bus.rf_dout <= mem[bus.rf_raddr];
   end

   int nvec = 0;
   int nerr = 0;
   int exp_cnt = 0;
   logic [DATA_W-1:0] frame_q [$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.in_valid = 1'b1; bus.in_data = '1; bus.rd_start = 1'b0; bus.out_ready = 1'b1;
      #3;
      nvec++;
      if ({bus.in_ready, bus.rf_wen, bus.frame_ready, bus.out_valid, bus.out_last} !== 5'b0) begin
         nerr++;
         $display("FAIL reset_ctl: got %b want 00000", {bus.in_ready, bus.rf_wen, bus.frame_ready, bus.out_valid, bus.out_last});
      end
      nvec++;
      if (bus.rf_waddr !== '0 || bus.rf_din !== '0 || bus.rf_raddr !== '0) begin
         nerr++;
         $display("FAIL reset_addr: waddr=%0d din=%h raddr=%0d want 0/0/0", bus.rf_waddr, bus.rf_din, bus.rf_raddr);
      end
`ifdef LPC_FRAME_CNT_EN
      nvec++;
      if (frame_cnt !== 16'd0) begin
         nerr++;
         $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
      end
`endif
      exp_cnt = 0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick;
      nvec++;
      if (bus.in_ready !== 1'b1) begin
         nerr++;
         $display("FAIL reset_to_fill: in_ready=%b want 1", bus.in_ready);
      end
   endtask

   // mode 0: in_data=i*3 every clock; mode 1: random data, gaps, stray rd_start
   task automatic test_fill(input int mode);
      int acc = 0;
      int cyc = 0;
      logic v;
      logic [DATA_W-1:0] d;
      frame_q.delete();
      while (acc < DEPTH && cyc < 4000) begin
         v = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
         d = (mode == 0) ? DATA_W'(acc * 3) : DATA_W'($urandom);
         bus.in_valid = v; bus.in_data = d;
         bus.rd_start = (mode != 0) && ($urandom_range(7) == 0);
         #1;
         nvec++;
         if (bus.in_ready !== 1'b1 || bus.rf_wen !== v || bus.frame_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL fill_ctl[%0d]: rdy=%b wen=%b fr=%b ov=%b want 1 %b 0 0", acc,
                     bus.in_ready, bus.rf_wen, bus.frame_ready, bus.out_valid, v);
         end
         if (v) begin
            nvec++;
            if (bus.rf_waddr !== acc[ADDR_W-1:0] || bus.rf_din !== d) begin
               nerr++;
               $display("FAIL fill_write[%0d]: addr=%0d din=%h want %0d %h", acc, bus.rf_waddr, bus.rf_din, acc, d);
            end
            frame_q.push_back(d);
            acc++;
         end
         tick;
         cyc++;
      end
      bus.in_valid = 1'b0; bus.rd_start = 1'b0;
      #1;
      nvec++;
      if (acc < DEPTH) begin
         nerr++;
         $display("FAIL fill_timeout: accepted %0d want %0d", acc, DEPTH);
      end
      nvec++;
      if (bus.frame_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
         nerr++;
         $display("FAIL fill_full: frame_ready=%b in_ready=%b want 1 0", bus.frame_ready, bus.in_ready);
      end
   endtask

   task automatic test_overrun;
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1; bus.in_data = 16'hFFFF;
         #1;
         nvec++;
         if (bus.rf_wen !== 1'b0 || bus.in_ready !== 1'b0 || bus.frame_ready !== 1'b1) begin
            nerr++;
            $display("FAIL overrun[%0d]: wen=%b rdy=%b fr=%b want 0 0 1", i, bus.rf_wen, bus.in_ready, bus.frame_ready);
         end
         tick;
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== frame_q[i]) bad++;
      nvec++;
      if (bad != 0) begin
         nerr++;
         $display("FAIL overrun_mem: %0d words changed want 0", bad);
      end
   endtask

   // mode 0: out_ready held high; mode 1: random out_ready and stray rd_start.
   // stop_at < DEPTH abandons the readout with sample stop_at pending.
   task automatic test_readout(input int mode, input int stop_at);
      int k = 0;
      int cyc = 0;
      logic r;
      logic [ADDR_W-1:0] exp_ra;
      bus.out_ready = 1'b0;
      bus.rd_start = 1'b1;
      tick;
      bus.rd_start = 1'b0;
      #1;
      nvec++;
      if (bus.out_valid !== 1'b0 || bus.rf_raddr !== '0 || bus.frame_ready !== 1'b0) begin
         nerr++;
         $display("FAIL prime: ov=%b raddr=%0d fr=%b want 0 0 0", bus.out_valid, bus.rf_raddr, bus.frame_ready);
      end
      tick;
      while (k < stop_at && cyc < 2000) begin
         r = (mode == 0) ? 1'b1 : 1'($urandom_range(1));
         bus.out_ready = r;
         bus.rd_start = (mode != 0) && ($urandom_range(5) == 0);
         #1;
         nvec++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== frame_q[k] || bus.out_last !== (k == DEPTH - 1)) begin
            nerr++;
            $display("FAIL read_data[%0d]: ov=%b data=%h last=%b want 1 %h %b", k,
                     bus.out_valid, bus.out_data, bus.out_last, frame_q[k], (k == DEPTH - 1));
         end
         exp_ra = r ? ADDR_W'(k + 1) : ADDR_W'(k);
         nvec++;
         if (bus.rf_raddr !== exp_ra) begin
            nerr++;
            $display("FAIL read_addr[%0d]: raddr=%0d want %0d", k, bus.rf_raddr, exp_ra);
         end
         if (r) k++;
         tick;
         cyc++;
      end
      bus.rd_start = 1'b0;
      nvec++;
      if (k < stop_at) begin
         nerr++;
         $display("FAIL read_timeout: delivered %0d want %0d", k, stop_at);
      end
      if (stop_at >= DEPTH) begin
         bus.out_ready = 1'b0;
         #1;
         exp_cnt = (exp_cnt + 1) & 16'hFFFF;
         nvec++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.frame_ready !== 1'b0) begin
            nerr++;
            $display("FAIL read_done: rdy=%b ov=%b fr=%b want 1 0 0", bus.in_ready, bus.out_valid, bus.frame_ready);
         end
`ifdef LPC_FRAME_CNT_EN
         nvec++;
         if (frame_cnt !== 16'(exp_cnt)) begin
            nerr++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
         end
`endif
      end
   endtask

   task automatic test_reset_mid_read;
      test_fill(1);
      test_readout(0, 80);
      bus.in_valid = 1'b1; bus.in_data = 16'h1234; bus.out_ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      nvec++;
      if ({bus.in_ready, bus.rf_wen, bus.frame_ready, bus.out_valid, bus.out_last} !== 5'b0 ||
          bus.rf_raddr !== '0 || bus.rf_waddr !== '0 || bus.rf_din !== '0) begin
         nerr++;
         $display("FAIL midread_reset: ctl=%b raddr=%0d waddr=%0d din=%h want 00000 0 0 0",
                  {bus.in_ready, bus.rf_wen, bus.frame_ready, bus.out_valid, bus.out_last},
                  bus.rf_raddr, bus.rf_waddr, bus.rf_din);
      end
`ifdef LPC_FRAME_CNT_EN
      nvec++;
      if (frame_cnt !== 16'd0) begin
         nerr++;
         $display("FAIL midread_cnt: got %0d want 0", frame_cnt);
      end
`endif
      exp_cnt = 0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick;
      nvec++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL midread_refill: rdy=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      test_fill(0);
      test_readout(1, DEPTH);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_fill(0);
      test_overrun;
      test_readout(0, DEPTH);
      test_fill(1);
      test_readout(1, DEPTH);
      test_fill(1);
      test_readout(0, DEPTH);
      test_reset_mid_read;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
